// File: rtl/mem_pkg.sv
// mem_pkg: width codes, FSM states and byte-count helper for the memory access unit
package mem_pkg;
  localparam logic [2:0] MW_NONE = 3'b000;
  localparam logic [2:0] MW_D    = 3'b001;
  localparam logic [2:0] MW_W    = 3'b010;
  localparam logic [2:0] MW_H    = 3'b011;
  localparam logic [2:0] MW_B    = 3'b100;
  localparam logic [2:0] MW_WU   = 3'b101;
  localparam logic [2:0] MW_HU   = 3'b110;
  localparam logic [2:0] MW_BU   = 3'b111;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
  function automatic logic [3:0] width_bytes(input logic [2:0] w);
    return (w == MW_B || w == MW_BU) ? 4'd1 :
           (w == MW_H || w == MW_HU) ? 4'd2 :
           (w == MW_W || w == MW_WU) ? 4'd4 :
           (w == MW_D) ? 4'd8 : 4'd0;
  endfunction
endpackage

// File: rtl/mem_access_unit_align.sv
// mem_align: byte-lane placement of store data, load extraction/extension and alignment check
module mem_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      width,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);
  logic [3:0]      bytes;
  logic [8:0]      lanes;
  logic [XLEN-1:0] raw;
  logic            sx;
  always_comb begin
    bytes      = width_bytes(width);
    lanes      = (9'd1 << bytes) - 9'd1;
    wmask      = lanes[7:0] << off;
    wdata      = store_data << {off, 3'b000};
    raw        = rdata >> {off, 3'b000};
    sx         = width == MW_B || width == MW_H || width == MW_W;
    misaligned = |({1'b0, off} & (bytes - 4'd1));
    load_data  = bytes == 4'd1 ? {{(XLEN-8){sx & raw[7]}}, raw[7:0]} :
                 bytes == 4'd2 ? {{(XLEN-16){sx & raw[15]}}, raw[15:0]} :
                 bytes == 4'd4 ? {{(XLEN-32){sx & raw[31]}}, raw[31:0]} : raw;
  end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: turns one decoded load/store into a memory request/response handshake
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic              is_load,
  input  logic              we_mem,
  input  logic [2:0]        memdata_width,
  input  logic [ADDR_W-1:0] addr,
  input  logic [XLEN-1:0]   store_data,
  output logic              stall,
  output logic              cmd_done,
  output logic [XLEN-1:0]   load_data,
  output logic              misaligned,
  output logic              misaligned_is_store,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [7:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);
  state_t            state, next;
  logic [2:0]        w_q;
  logic [ADDR_W-1:0] a_q;
  logic [XLEN-1:0]   sd_q, ld_q, al_wdata, al_load;
  logic [7:0]        al_wmask;
  logic              we_q, mis_q, mis_st_q, access, start, al_mis, req, capture;
  assign access   = cmd_valid && (is_load || we_mem) && memdata_width != MW_NONE;
  assign cmd_done = state == S_DONE || mis_q;
  assign stall    = access && !cmd_done;
  // the misaligned-done cycle still sees the held command, so it must not restart
  assign start    = state == S_IDLE && access && !mis_q;
  assign req      = state == S_REQ;
  assign capture  = !we_q && mem_resp_valid && ((req && mem_req_ready) || state == S_WAIT);
  mem_align #(.XLEN(XLEN)) u_align (
    .width      (state == S_IDLE ? memdata_width : w_q),
    .off        (state == S_IDLE ? addr[2:0] : a_q[2:0]),
    .store_data (sd_q),
    .rdata      (mem_resp_rdata),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .load_data  (al_load),
    .misaligned (al_mis)
  );
  always_comb begin
    next = state;
    unique case (state)
      S_IDLE:  next = start && !al_mis ? S_REQ : S_IDLE;
      S_REQ:   next = !mem_req_ready ? S_REQ : (we_q || mem_resp_valid) ? S_DONE : S_WAIT;
      S_WAIT:  next = mem_resp_valid ? S_DONE : S_WAIT;
      default: next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      w_q      <= '0;
      a_q      <= '0;
      sd_q     <= '0;
      ld_q     <= '0;
      we_q     <= 1'b0;
      mis_q    <= 1'b0;
      mis_st_q <= 1'b0;
    end else begin
      state    <= next;
      mis_q    <= start && al_mis;
      mis_st_q <= start && al_mis && we_mem && !is_load;
      if (start && !al_mis) begin
        w_q  <= memdata_width;
        a_q  <= addr;
        sd_q <= store_data;
        we_q <= we_mem && !is_load;
      end
      if (capture) ld_q <= al_load;
    end
  end
  assign load_data           = ld_q;
  assign misaligned          = mis_q;
  assign misaligned_is_store = mis_st_q;
  assign mem_req_valid       = req;
  assign mem_req_we          = req && we_q;
  assign mem_req_addr        = req ? {a_q[ADDR_W-1:3], 3'b000} : '0;
  assign mem_req_wdata       = req && we_q ? al_wdata : '0;
  assign mem_req_wmask       = req && we_q ? al_wmask : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed accesses checked against a spec-level model every cycle
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, is_load = 1'b0, we_mem = 1'b0;
  logic [2:0]  memdata_width = 3'b000;
  logic [63:0] addr = '0, store_data = '0, mem_resp_rdata = '0;
  logic        mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic        stall, cmd_done, misaligned, misaligned_is_store, mem_req_valid, mem_req_we;
  logic [63:0] load_data, mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  int n_cmp = 0, n_bad = 0;
  logic [63:0] exp_addr, exp_wdata, exp_ld;
  logic [7:0]  exp_wmask;
  logic        exp_we, exp_mis, exp_mis_st, exp_is_load;
  logic [63:0] last_ld, last_a, last_w;
  logic [7:0]  last_m;
  logic        last_v;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .is_load(is_load), .we_mem(we_mem),
    .memdata_width(memdata_width), .addr(addr), .store_data(store_data),
    .stall(stall), .cmd_done(cmd_done), .load_data(load_data), .misaligned(misaligned),
    .misaligned_is_store(misaligned_is_store), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] w);
    case (w)
      3'b100, 3'b111: return 1;
      3'b011, 3'b110: return 2;
      3'b010, 3'b101: return 4;
      3'b001:         return 8;
      default:        return 0;
    endcase
  endfunction

  task automatic set_model(input logic ld, input logic st, input logic [2:0] w,
                           input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd);
    int n, off;
    logic [63:0] m, raw;
    logic store;
    n = nbytes(w);
    off = int'(a[2:0]);
    m = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    store = st && !ld;
    exp_is_load = !store;
    exp_mis = (a % 64'(n)) != 0;
    exp_mis_st = store;
    exp_we = store;
    exp_addr = a & ~64'h7;
    exp_wdata = store ? (sd << (8 * off)) : 64'd0;
    exp_wmask = store ? 8'(((1 << n) - 1) << off) : 8'd0;
    raw = (rd >> (8 * off)) & m;
    if ((w == 3'b100 || w == 3'b011 || w == 3'b010) && raw[8*n-1]) raw = raw | ~m;
    exp_ld = raw;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("stall", stall, cmd_valid && (is_load || we_mem) && memdata_width != 3'b000 && !cmd_done);
      if (mem_req_valid) begin
        check("req_addr", mem_req_addr, exp_addr);
        check("req_we", mem_req_we, exp_we);
        check("req_wdata", mem_req_wdata, exp_wdata);
        check("req_wmask", mem_req_wmask, exp_wmask);
      end
      if (cmd_done) begin
        check("misaligned", misaligned, exp_mis);
        if (exp_mis) check("misaligned_is_store", misaligned_is_store, exp_mis_st);
        else if (exp_is_load) check("load_data", load_data, exp_ld);
      end else check("misaligned_idle", misaligned, 0);
    end
  end

  task automatic run(input string nm, input logic ld, input logic st, input logic [2:0] w,
                     input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rd,
                     input int rdy_dly, input int resp_dly, input int exp_cyc);
    int hs, vcnt, done_cyc;
    @(posedge clk); #1;
    cmd_valid = 1; is_load = ld; we_mem = st; memdata_width = w;
    addr = a; store_data = sd; mem_resp_rdata = rd;
    set_model(ld, st, w, a, sd, rd);
    hs = -1; vcnt = 0; done_cyc = 0; last_v = 0;
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      mem_req_ready = mem_req_valid && vcnt >= rdy_dly;
      if (mem_req_valid) begin
        vcnt++;
        last_v = 1; last_a = mem_req_addr; last_w = mem_req_wdata; last_m = mem_req_wmask;
      end
      if (mem_req_valid && mem_req_ready) hs = c;
      mem_resp_valid = ld && hs >= 0 && c - hs == resp_dly;
      @(negedge clk);
      if (cmd_done) begin done_cyc = c; last_ld = load_data; end
    end
    check({nm, " done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
  endtask

  initial begin
    @(posedge clk); #1;
    @(negedge clk);
    check("rst outputs", {stall, cmd_done, misaligned, misaligned_is_store, mem_req_valid, mem_req_we}, 0);
    check("rst addr|data", mem_req_addr | mem_req_wdata | load_data | 64'(mem_req_wmask), 0);
    @(posedge clk); #1 rst = 0;

    run("sb", 0, 1, 3'b100, 64'h1003, 64'hAB, 0, 0, 0, 3);
    check("sb addr", last_a, 64'h1000);
    check("sb wmask", 64'(last_m), 64'h08);
    check("sb wdata", last_w, 64'h0000_0000_AB00_0000);
    run("lb", 1, 0, 3'b100, 64'h2005, 0, 64'h0000_8000_0000_0000, 0, 2, 5);
    check("lb lit", last_ld, 64'hFFFF_FFFF_FFFF_FF80);
    run("lbu", 1, 0, 3'b111, 64'h2005, 0, 64'h0000_8000_0000_0000, 0, 2, 5);
    check("lbu lit", last_ld, 64'h80);
    run("lw mis", 1, 0, 3'b010, 64'h3006, 0, 0, 0, 0, 2);
    check("lw mis no_req", 64'(last_v), 0);
    run("sd mis", 0, 1, 3'b001, 64'h3004, 64'h55, 0, 0, 0, 2);
    check("sd mis no_req", 64'(last_v), 0);
    run("ld slow", 1, 0, 3'b001, 64'h4000, 0, 64'h1122_3344_5566_7788, 5, 0, 8);
    check("ld lit", last_ld, 64'h1122_3344_5566_7788);
    run("lw fast", 1, 0, 3'b010, 64'h4004, 0, 64'h8765_4321_0000_0000, 0, 0, 3);
    check("lw lit", last_ld, 64'hFFFF_FFFF_8765_4321);
    run("lwu", 1, 0, 3'b101, 64'h4004, 0, 64'h8765_4321_0000_0000, 0, 1, 4);
    check("lwu lit", last_ld, 64'h0000_0000_8765_4321);
    run("ld+we as load", 1, 1, 3'b010, 64'h4004, 64'hFF, 64'h8765_4321_0000_0000, 0, 0, 3);
    check("ld+we no write", 64'(last_m), 0);
    run("sh", 0, 1, 3'b011, 64'h16, 64'h1234, 0, 0, 0, 3);
    check("sh wdata", last_w, 64'h1234_0000_0000_0000);
    check("sh wmask", 64'(last_m), 64'hC0);
    run("sw slow", 0, 1, 3'b010, 64'h8, 64'hDEAD_BEEF, 0, 2, 0, 5);
    run("sd", 0, 1, 3'b001, 64'h18, 64'h0102_0304_0506_0708, 0, 0, 0, 3);
    check("sd wmask", 64'(last_m), 64'hFF);
    run("lh neg", 1, 0, 3'b011, 64'h22, 0, 64'h0000_0000_F00D_0000, 0, 0, 3);
    check("lh lit", last_ld, 64'hFFFF_FFFF_FFFF_F00D);

    @(posedge clk); #1;
    cmd_valid = 1; is_load = 0; we_mem = 0; memdata_width = 3'b000;
    mem_req_ready = 0; mem_resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("noop stall", stall, 0);
      check("noop req", mem_req_valid, 0);
      if (i == 1) is_load = 1;
    end

    @(posedge clk); #1;
    cmd_valid = 1; is_load = 1; we_mem = 0; memdata_width = 3'b110;
    addr = 64'h5002; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    set_model(1, 0, 3'b110, 64'h5002, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1 mem_req_ready = mem_req_valid;
    @(posedge clk); #1 mem_req_ready = 0; rst = 1; cmd_valid = 0;
    @(posedge clk); #1 rst = 0; mem_resp_valid = 1;
    @(negedge clk);
    check("rst mid ctl", {stall, cmd_done, misaligned, misaligned_is_store, mem_req_valid, mem_req_we}, 0);
    check("rst mid data", mem_req_addr | mem_req_wdata | load_data | 64'(mem_req_wmask), 0);
    @(posedge clk); #1 mem_resp_valid = 0;
    @(negedge clk);
    check("late resp done", cmd_done, 0);
    check("late resp req", mem_req_valid, 0);
    check("late resp data", load_data, 0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage responder to the instruction decoder's load/store control outputs (is_load, we_mem, memdata_width).
- Converts one decoded access into a request/response handshake on a 64-bit data-memory port, with byte-lane alignment, write masks, sign/zero extension and misalignment detection.
- Holds the pipeline via stall until the access completes.
- Sits between the EX/MEM pipeline register and the data memory/bus.

Parameters:
- XLEN, 64, datapath and register width.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  MEM stage holds a valid instruction
- is_load  in  1  load command, from decoder
- we_mem  in  1  store command, from decoder
- memdata_width  in  3  width code: 100 b, 011 h, 010 w, 001 d, 111 bu, 110 hu, 101 wu, 000 none
- addr  in  ADDR_W  effective address, ALU result
- store_data  in  XLEN  rs2 value
- stall  out  1  freeze the pipeline; MEM inputs must be held stable while high
- cmd_done  out  1  one-cycle pulse when the access completes
- load_data  out  XLEN  extended load result, valid while cmd_done is high
- misaligned  out  1  one-cycle pulse on a misaligned access (trap cause)
- misaligned_is_store  out  1  qualifies misaligned: 1 = store/AMO address misaligned, 0 = load
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  write request
- mem_req_addr  out  ADDR_W  address with addr[2:0] forced to 0
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_req_wmask  out  8  byte enables
- mem_resp_valid  in  1  read data valid
- mem_resp_rdata  in  XLEN  read data, aligned doubleword

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs are 0: stall, cmd_done, misaligned, misaligned_is_store, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask, load_data.
- Access condition: an access is cmd_valid && (is_load || we_mem) && memdata_width != 000. Anything else is a no-op: stall=0, no request issued.
- Byte count:
  - b/bu → 1; h/hu → 2; w/wu → 4; d → 8.
  - The access is misaligned if addr mod bytes != 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - Access that is misaligned: register misaligned=1, misaligned_is_store=we_mem and cmd_done=1 for the next cycle. No memory request. Return to IDLE.
  - Aligned access: latch the command, then go to REQ with mem_req_valid=1 on the next cycle.
- REQ:
  - Hold mem_req_* stable until mem_req_ready=1.
  - On handshake, a store goes to DONE.
  - On handshake, a load goes to WAIT. If mem_resp_valid=1 in the same cycle, it goes straight to DONE and captures the data.
- WAIT: stay until mem_resp_valid=1; capture the extended data, then go to DONE.
- DONE: cmd_done=1 and load_data is valid for exactly one cycle, then return to IDLE.
- Stall:
  - stall = access && !cmd_done (combinational), including the IDLE cycle in which the access is first seen.
  - Minimum access latency is 3 cycles (IDLE→REQ→DONE).
  - The pipeline advances on the cycle cmd_done=1.
- Back-to-back: after DONE the unit returns to IDLE, so a new command is accepted one cycle after cmd_done.
- Store lanes, with off = addr[2:0]:
  - mem_req_wdata = store_data << (8*off).
  - mem_req_wmask = ((1<<bytes)-1) << off.
- Load extraction:
  - raw = mem_resp_rdata >> (8*off), truncated to bytes.
  - Signed codes (b, h, w) sign-extend to XLEN; unsigned codes (bu, hu, wu) zero-extend; d passes through.
- mem_req_we=1 for stores, 0 for loads. For loads, wmask=0 and wdata=0.
- Stray traffic: mem_resp_valid is ignored outside REQ and WAIT. is_load and we_mem both set is illegal; treat it as a load.
- Reset mid-access: the unit returns to IDLE on the same edge and mem_req_valid drops. A late response after reset is ignored.

Decomposition:
- Package mem_pkg holds:
  - Width-code localparams (MW_B=3'b100, MW_H=3'b011, MW_W=3'b010, MW_D=3'b001, MW_BU=3'b111, MW_HU=3'b110, MW_WU=3'b101, MW_NONE=3'b000).
  - The state encoding.
  - The bytes-from-width function.
- Sub-module mem_align: purely combinational. Takes (width, off, store_data, rdata) and produces (wdata, wmask, load_data, misaligned).

Test Plan:
- sb, addr=0x1003, store_data=0xAB, ready=1 → mem_req_addr=0x1000, wmask=0x08, wdata=0x00000000AB000000; cmd_done on cycle 3; stall high in cycles 1–2.
- lb, addr=0x2005, rdata=0x0000_8000_0000_0000, response 2 cycles after handshake → load_data=0xFFFF_FFFF_FFFF_FF80; same access as lbu → 0x80.
- lw, addr=0x3006 → misaligned=1, misaligned_is_store=0, cmd_done next cycle, mem_req_valid never asserted; sd, addr=0x3004 → misaligned=1, misaligned_is_store=1.
- ld, addr=0x4000, mem_req_ready held low 5 cycles → mem_req_* stable throughout, stall held; rdata 0x1122334455667788 returned intact.
- lhu in WAIT, assert rst one cycle, then a late mem_resp_valid → state IDLE, all outputs 0, no cmd_done; with cmd_valid=0 the next cycle, stall=0.
- cmd_valid=1 with memdata_width=000 (add instruction) → stall=0, no request; lw with response in the same cycle as the handshake → cmd_done on cycle 3.
